// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic pipeline-stage register with optional skid entry, flush and stall counter
module pipe_stage_buf #(
    parameter int                DATA_W      = 160,
    parameter int                CTRL_W      = 24,
    parameter logic [CTRL_W-1:0] KILL_MASK   = {CTRL_W{1'b1}},
    parameter int                SKID        = 1,
    parameter int                STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [CTRL_W-1:0]      in_ctrl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CTRL_W-1:0]      out_ctrl,
    input  logic                   stall_cnt_clr,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_W-1:0]       main_data_q, main_data_d;
    logic [CTRL_W-1:0]       main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]       skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]       skid_ctrl_q, skid_ctrl_d;
    logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic                    in_fire;
    logic                    out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign stall_cnt = stall_cnt_q;

    // The skid variant decodes ready from state only, so no in_* to out_* path exists.
    if (SKID != 0) begin : g_skid
        assign in_ready = (state_q != ST_FULL);
    end else begin : g_single
        assign in_ready = ~out_valid | out_ready;
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d     = ST_ONE;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (in_fire) begin
                    state_d     = ST_FULL;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end else if (out_fire) begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = main_ctrl_q & ~KILL_MASK;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d     = ST_ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: begin
                state_d     = ST_EMPTY;
                main_ctrl_d = main_ctrl_q & ~KILL_MASK;
            end
        endcase

        // Flush drops whatever the case above loaded, including a same-cycle in_fire.
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = main_data_q;
            main_ctrl_d = main_ctrl_q & ~KILL_MASK;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
